// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit (1), DATA_W data bits MSB first, optional even parity, stop bit (0).
// Good frames land in a one-entry output register with a valid/ready handshake; errors pulse for one cycle.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift;
  logic [DATA_W:0]    shift_ext;
  logic               par_bad;
  logic               last_bit;
  logic               reg_free;

  // The widened shift path keeps DATA_W=1 legal and doubles as the parity XOR input.
  assign shift_ext = {shift, serial_in};
  assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
  assign reg_free  = !data_valid || data_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (serial_in) state_next = DATA;
      DATA:    if (last_bit) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;

      case (state)
        IDLE: begin
          if (serial_in) begin
            bit_cnt <= '0;
            par_bad <= 1'b0;
          end
        end
        DATA: begin
          shift   <= shift_ext[DATA_W-1:0];
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        PARITY:  par_bad <= ^shift_ext;
        default: ;
      endcase

      if (data_valid && data_ready) data_valid <= 1'b0;

      // Stop-bit verdict: framing beats parity, and a full, undrained register drops the new word.
      if (state == STOP) begin
        if (serial_in) begin
          frame_err <= 1'b1;
        end else if (par_bad) begin
          parity_err <= 1'b1;
        end else if (reg_free) begin
          data_out   <= shift;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized and directed bench for serial_frame_rx at the default parameters,
// checked cycle by cycle against a frame-level model of the output register and error flags.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic       mValid = 1'b0;
  logic [7:0] mData  = 8'h00;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // endKind: 0 = mid-frame or idle, 1 = good frame ends, 2 = stop bit was 1, 3 = parity bad
  task automatic tick(input logic sIn, input logic rdy, input logic rst,
                      input int endKind, input logic [7:0] word, input logic expBusy);
    logic eF, eP, eO, free;
    serial_in  = sIn;
    data_ready = rdy;
    reset      = rst;
    eF = 1'b0; eP = 1'b0; eO = 1'b0;
    if (rst) begin
      mValid = 1'b0;
      mData  = 8'h00;
    end else begin
      free = !mValid || rdy;
      if (mValid && rdy) mValid = 1'b0;
      case (endKind)
        1: if (free) begin mValid = 1'b1; mData = word; end else eO = 1'b1;
        2: eF = 1'b1;
        3: eP = 1'b1;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    checkOutput("data_valid", 16'(data_valid), 16'(mValid));
    if (mValid || rst) checkOutput("data_out", 16'(data_out), 16'(mData));
    checkOutput("frame_err", 16'(frame_err), 16'(eF));
    checkOutput("parity_err", 16'(parity_err), 16'(eP));
    checkOutput("overrun", 16'(overrun), 16'(eO));
    checkOutput("busy", 16'(busy), 16'(rst ? 1'b0 : expBusy));
    @(negedge clk);
  endtask

  function automatic logic pickReady(input int mode, input bit isStop);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return isStop ? 1'b1 : 1'b0;
    endcase
  endfunction

  // Sends one frame; abortAt >= 0 asserts reset in place of data bit number abortAt.
  task automatic applyStimulus(input logic [7:0] word, input bit flipPar, input bit stopBit,
                               input int rdyMode, input int abortAt);
    tick(1'b1, pickReady(rdyMode, 0), 1'b0, 0, word, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      if (abortAt == 7 - i) begin
        tick(1'b0, pickReady(rdyMode, 0), 1'b1, 0, word, 1'b0);
        return;
      end
      tick(word[i], pickReady(rdyMode, 0), 1'b0, 0, word, 1'b1);
    end
    tick((^word) ^ flipPar, pickReady(rdyMode, 0), 1'b0, 0, word, 1'b1);
    tick(stopBit, pickReady(rdyMode, 1), 1'b0, stopBit ? 2 : (flipPar ? 3 : 1), word, 1'b0);
  endtask

  task automatic idle(input int n, input int rdyMode);
    for (int i = 0; i < n; i++) tick(1'b0, pickReady(rdyMode, 0), 1'b0, 0, 8'h00, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    serial_in  = 1'b0;
    data_ready = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0);

    $display("[TB] idle line after reset");
    idle(20, 2);

    $display("[TB] single good frame 0xA5");
    applyStimulus(8'hA5, 0, 0, 1, -1);
    idle(2, 1);

    $display("[TB] parity error then framing error on 0x3C");
    applyStimulus(8'h3C, 1, 0, 1, -1);
    applyStimulus(8'h3C, 0, 1, 1, -1);
    idle(2, 1);

    $display("[TB] overrun with back-to-back frames");
    applyStimulus(8'h11, 0, 0, 0, -1);
    applyStimulus(8'h22, 0, 0, 0, -1);
    idle(2, 0);
    idle(2, 1);

    $display("[TB] drain on the stop edge");
    applyStimulus(8'h11, 0, 0, 0, -1);
    applyStimulus(8'h22, 0, 0, 3, -1);
    idle(2, 0);
    idle(2, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hC3, 0, 0, 1, 4);
    idle(1, 1);
    applyStimulus(8'h5A, 0, 0, 1, -1);
    idle(2, 1);

    $display("[TB] random frames");
    for (int f = 0; f < 60; f++) begin
      applyStimulus(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    2, -1);
      idle($urandom_range(0, 2), 2);
    end
    idle(4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 8-stage serial delay line. Runs at one bit per clock.
- Accepts a framed bit stream on serial_in: a start bit, DATA_W data bits sent MSB first, an optional even-parity bit, and a stop bit.
- Reassembles each valid frame into a parallel word held in a one-entry output register with a valid/ready handshake.
- Flags framing, parity and overrun errors.
- The line idles at 0, matching the delay line's post-reset output.

Parameters:
DATA_W, 8, data bits per frame (1..16).
PARITY_EN, 1, 1 = a parity bit follows the data and is checked for even parity (data bits plus parity bit XOR to 0); 0 = no parity bit.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
serial_in  input  1  serial bit stream; idle 0, start bit 1, stop bit 0.
data_out  output  DATA_W  received word; stable while data_valid=1.
data_valid  output  1  data_out holds an unconsumed word.
data_ready  input  1  consumer accepts data_out on a cycle where data_valid=1 and data_ready=1.
frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
parity_err  output  1  one-cycle pulse: parity mismatch.
overrun  output  1  one-cycle pulse: a good frame completed while the output register was full and not being drained.
busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk):
  - FSM goes to IDLE; the bit counter and shift register clear.
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame aborts the frame and discards any held word without flagging an error.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: serial_in=1 is the start bit; go to DATA and clear bit_cnt. serial_in=0 stays in IDLE.
  - DATA: shift[DATA_W-1:0] <= {shift[DATA_W-2:0], serial_in}; increment bit_cnt. After DATA_W bits, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: compute par_bad = XOR(shift, serial_in); go to STOP.
  - STOP: always return to IDLE next cycle. A 1 sampled in STOP is never treated as a start bit.
- Frame length is 1 + DATA_W + PARITY_EN + 1 cycles; 11 cycles at the defaults. Back-to-back frames are legal: a start bit may arrive on the cycle right after STOP.
- Evaluation on the STOP edge, in priority order:
  - serial_in=1: frame_err pulses next cycle; the word is discarded and parity is not reported.
  - else par_bad=1: parity_err pulses next cycle; the word is discarded.
  - else good frame:
    - If the output register is free (data_valid=0, or data_valid=1 and data_ready=1 on the same cycle), data_out <= shift and data_valid <= 1.
    - Otherwise the new word is dropped, overrun pulses, and the old word is kept unchanged.
- Latency: data_valid is first visible in the cycle after the stop bit is presented. That is 11 cycles after the start bit at the defaults.
- Handshake:
  - data_valid stays high and data_out stays stable until the cycle with data_ready=1; data_valid falls after that edge unless a new word loads on the same edge.
  - data_ready while data_valid=0 has no effect.
- Error pulses are exactly one cycle wide and never coincide with a data_valid rise for the same frame.
- busy=1 in DATA, PARITY and STOP.

Test Plan:
1. After reset, hold serial_in=0 for 20 cycles -> data_valid, busy and all error flags stay 0; data_out=0.
2. Defaults, data_ready=1; send 1, 0xA5 MSB first, parity 0, stop 0 -> data_valid=1 with data_out=0xA5 for exactly one cycle, 11 cycles after the start bit; no errors.
3. Send 0x3C with parity bit 1 -> parity_err pulses once, data_valid stays 0. Then send 0x3C with stop bit 1 -> frame_err pulses once, parity_err stays 0.
4. data_ready=0; send 0x11 then back-to-back 0x22 -> data_out=0x11 held, overrun pulses at the end of the second frame. Raise data_ready -> 0x11 is consumed and data_valid falls.
5. data_valid=1 holding 0x11; assert data_ready exactly on the STOP edge of frame 0x22 -> data_out=0x22, data_valid stays 1, no overrun.
6. Assert reset after the 4th data bit of a frame -> busy=0 next cycle, no error pulse; a following frame 0x5A is received correctly.
